// File: rtl/cpu_sdram_bridge_pkg.sv
// m92_pkg: shared types and sizes for the M92 CPU-to-SDRAM bridge
package m92_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} cpu_bridge_state_t;
  localparam int LINE_WORDS = 4;
  localparam int CPU_LINE_BITS = 16 * LINE_WORDS;
  localparam int CPU_TAG_W = 22;
  function automatic logic [15:0] line_word(input logic [CPU_LINE_BITS-1:0] l, input logic [1:0] i);
    return l[{i, 4'h0} +: 16];
  endfunction
endpackage

// File: rtl/cpu_sdram_bridge_if.sv
// cpu_sdram_bridge_if: decoder/CPU-side strobes plus the SDRAM controller CPU port
interface cpu_sdram_bridge_if;
  import m92_pkg::*;
  logic mem_rd, mem_wr, ram_rom_memrq, writable;
  logic [24:0] sdr_addr;
  logic [1:0] cpu_be;
  logic [15:0] cpu_dout, cpu_din;
  logic cpu_ready, sdr_req, sdr_we, sdr_ack;
  logic [24:0] sdr_a;
  logic [1:0] sdr_be;
  logic [15:0] sdr_wdata;
  logic [CPU_LINE_BITS-1:0] sdr_rdata;
  modport master(
    input mem_rd, mem_wr, ram_rom_memrq, writable, sdr_addr, cpu_be, cpu_dout, sdr_rdata, sdr_ack,
    output cpu_din, cpu_ready, sdr_req, sdr_we, sdr_a, sdr_be, sdr_wdata
  );
  modport slave(
    output mem_rd, mem_wr, ram_rom_memrq, writable, sdr_addr, cpu_be, cpu_dout, sdr_rdata, sdr_ack,
    input cpu_din, cpu_ready, sdr_req, sdr_we, sdr_a, sdr_be, sdr_wdata
  );
endinterface

// File: rtl/cpu_sdram_bridge_line_cache.sv
// cpu_line_cache: single 64-bit line with tag/valid; filled on read, byte-merged on matching writes
module cpu_line_cache
  import m92_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic [CPU_TAG_W-1:0] look_tag,
  output logic hit,
  output logic [CPU_LINE_BITS-1:0] line,
  input  logic [CPU_TAG_W-1:0] req_tag,
  input  logic fill,
  input  logic [CPU_LINE_BITS-1:0] fill_line,
  input  logic wr,
  input  logic [1:0] wr_idx,
  input  logic [1:0] wr_be,
  input  logic [15:0] wr_data
);
  logic valid;
  logic [CPU_TAG_W-1:0] tag;
  logic [CPU_LINE_BITS-1:0] merged;
  assign hit = valid && tag == look_tag;
  always_comb begin
    merged = line;
    if (wr_be[0]) merged[{wr_idx, 4'h0} +: 8] = wr_data[7:0];
    if (wr_be[1]) merged[{wr_idx, 4'h8} +: 8] = wr_data[15:8];
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      valid <= 1'b0;
      tag <= '0;
      line <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag <= req_tag;
      line <= fill_line;
    end else if (wr && valid && req_tag == tag) begin
      line <= merged;
    end
endmodule

// File: rtl/cpu_sdram_bridge.sv
// cpu_sdram_bridge: turns decoded V33 bus cycles into SDRAM req/ack transactions, stalling via cpu_ready.
// Define M92_CPU_LINE_CACHE_EN to add a one-line read cache in front of the SDRAM port.
module cpu_sdram_bridge
  import m92_pkg::*;
(
  input logic clk,
  input logic reset_n,
  cpu_sdram_bridge_if.master bus
);
  cpu_bridge_state_t state, state_d;
  logic [15:0] cpu_din_d, sdr_wdata_d;
  logic [24:0] sdr_a_d;
  logic [1:0] sdr_be_d, sel, sel_d;
  logic cpu_ready_d, sdr_req_d, sdr_we_d;
  logic wr_go, rd_go, fill, merge, hit;
  logic [CPU_LINE_BITS-1:0] line;
  assign wr_go = state == IDLE && bus.mem_wr && bus.ram_rom_memrq && bus.writable;
  assign rd_go = state == IDLE && bus.mem_rd && !bus.mem_wr && bus.ram_rom_memrq;
  assign fill = state == RD_WAIT && bus.sdr_ack;
  assign merge = state == WR_WAIT && bus.sdr_ack;
`ifdef M92_CPU_LINE_CACHE_EN
  cpu_line_cache u_cache (
    .clk(clk),
    .reset_n(reset_n),
    .look_tag(bus.sdr_addr[24:3]),
    .hit(hit),
    .line(line),
    .req_tag(bus.sdr_a[24:3]),
    .fill(fill),
    .fill_line(bus.sdr_rdata),
    .wr(merge),
    .wr_idx(bus.sdr_a[2:1]),
    .wr_be(bus.sdr_be),
    .wr_data(bus.sdr_wdata)
  );
`else
  assign hit = 1'b0;
  assign line = '0;
`endif
  always_comb begin
    state_d = state;
    cpu_din_d = bus.cpu_din;
    cpu_ready_d = bus.cpu_ready;
    sdr_req_d = bus.sdr_req;
    sdr_we_d = bus.sdr_we;
    sdr_a_d = bus.sdr_a;
    sdr_be_d = bus.sdr_be;
    sdr_wdata_d = bus.sdr_wdata;
    sel_d = sel;
    if (wr_go) begin
      state_d = WR_WAIT;
      sdr_req_d = 1'b1;
      sdr_we_d = 1'b1;
      cpu_ready_d = 1'b0;
      sdr_a_d = bus.sdr_addr & ~25'h1;
      sdr_be_d = bus.cpu_be;
      sdr_wdata_d = bus.cpu_dout;
    end else if (rd_go && hit) begin
      cpu_din_d = line_word(line, bus.sdr_addr[2:1]);
    end else if (rd_go) begin
      state_d = RD_WAIT;
      sdr_req_d = 1'b1;
      sdr_we_d = 1'b0;
      cpu_ready_d = 1'b0;
      sdr_a_d = bus.sdr_addr & ~25'h7;
      sdr_be_d = 2'b11;
      sel_d = bus.sdr_addr[2:1];
    end else if (fill || merge) begin
      state_d = IDLE;
      sdr_req_d = 1'b0;
      cpu_ready_d = 1'b1;
      cpu_din_d = fill ? line_word(bus.sdr_rdata, sel) : bus.cpu_din;
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      sel <= '0;
      bus.cpu_din <= '0;
      bus.cpu_ready <= 1'b1;
      bus.sdr_req <= 1'b0;
      bus.sdr_we <= 1'b0;
      bus.sdr_a <= '0;
      bus.sdr_be <= '0;
      bus.sdr_wdata <= '0;
    end else begin
      state <= state_d;
      sel <= sel_d;
      bus.cpu_din <= cpu_din_d;
      bus.cpu_ready <= cpu_ready_d;
      bus.sdr_req <= sdr_req_d;
      bus.sdr_we <= sdr_we_d;
      bus.sdr_a <= sdr_a_d;
      bus.sdr_be <= sdr_be_d;
      bus.sdr_wdata <= sdr_wdata_d;
    end
endmodule

// File: tb/tb_cpu_sdram_bridge.sv
// tb_cpu_sdram_bridge: directed stimulus with a read-data scoreboard drained by a monitor
module tb_cpu_sdram_bridge;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] q[$];
  localparam logic [63:0] L1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] L2 = 64'h8888_7777_6666_5555;
  cpu_sdram_bridge_if bus();
  cpu_sdram_bridge dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [24:0] a, input logic [15:0] exp);
    bus.sdr_addr = a;
    bus.ram_rom_memrq = 1'b1;
    bus.writable = 1'b0;
    bus.mem_rd = 1'b1;
    q.push_back(exp);
    tick;
    bus.mem_rd = 1'b0;
  endtask

  task automatic wr(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be, input logic w);
    bus.sdr_addr = a;
    bus.ram_rom_memrq = 1'b1;
    bus.writable = w;
    bus.cpu_dout = d;
    bus.cpu_be = be;
    bus.mem_wr = 1'b1;
    tick;
    bus.mem_wr = 1'b0;
  endtask

  task automatic ack(input logic [63:0] l);
    bus.sdr_rdata = l;
    bus.sdr_ack = 1'b1;
    tick;
    bus.sdr_ack = 1'b0;
    check("done_req", bus.sdr_req, 0);
    check("done_ready", bus.cpu_ready, 1);
  endtask

  task automatic miss(input string n, input logic [24:0] ea, input logic [63:0] l);
    check({n, "_req"}, bus.sdr_req, 1);
    check({n, "_we"}, bus.sdr_we, 0);
    check({n, "_a"}, bus.sdr_a, ea);
    check({n, "_be"}, bus.sdr_be, 2'b11);
    check({n, "_ready"}, bus.cpu_ready, 0);
    tick;
    tick;
    check({n, "_hold"}, bus.sdr_req, 1);
    ack(l);
  endtask

  task automatic hit_or_miss(input string n, input logic [24:0] ea, input logic [63:0] l);
`ifdef M92_CPU_LINE_CACHE_EN
    check({n, "_hit_noreq"}, bus.sdr_req, 0);
    check({n, "_hit_ready"}, bus.cpu_ready, 1);
    if (l == 64'h0) check({n, "_unused"}, ea, ea + 25'h0);
`else
    miss(n, ea, l);
`endif
  endtask

  initial begin : monitor
    forever begin
      logic [15:0] exp;
      int n;
      @(negedge clk);
      if (reset_n && bus.mem_rd && !bus.mem_wr && bus.ram_rom_memrq) begin
        n = 0;
        exp = 16'h0;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got read with no expected value");
        end else exp = q.pop_front();
        do begin
          @(negedge clk);
          n++;
        end while (!bus.cpu_ready && n < 200);
        if (!bus.cpu_ready) begin
          total++;
          bad++;
          $display("FAIL rd_timeout: cpu_ready=0 expected 1 within 200 cycles");
        end else check("rd_data", bus.cpu_din, exp);
      end
    end
  end

  initial begin
    logic saw_req, saw_stall;
    bus.mem_rd = 0; bus.mem_wr = 0; bus.ram_rom_memrq = 0; bus.writable = 0;
    bus.sdr_addr = '0; bus.cpu_be = 0; bus.cpu_dout = 0; bus.sdr_rdata = '0; bus.sdr_ack = 0;
    repeat (3) tick;
    check("rst_ready", bus.cpu_ready, 1);
    check("rst_req", bus.sdr_req, 0);
    check("rst_we", bus.sdr_we, 0);
    check("rst_a", bus.sdr_a, 0);
    check("rst_be", bus.sdr_be, 0);
    check("rst_wdata", bus.sdr_wdata, 0);
    check("rst_din", bus.cpu_din, 0);
    reset_n = 1'b1;
    tick;
    rd(25'h0012346, 16'h4444);
    miss("rd1", 25'h0012340, L1);
    tick;
    wr(25'h0100010, 16'hBEEF, 2'b10, 1'b1);
    check("wr_req", bus.sdr_req, 1);
    check("wr_we", bus.sdr_we, 1);
    check("wr_a", bus.sdr_a, 25'h0100010);
    check("wr_be", bus.sdr_be, 2'b10);
    check("wr_data", bus.sdr_wdata, 16'hBEEF);
    check("wr_ready", bus.cpu_ready, 0);
    repeat (3) tick;
    check("wr_hold_data", bus.sdr_wdata, 16'hBEEF);
    check("wr_hold_ready", bus.cpu_ready, 0);
    check("wr_hold_req", bus.sdr_req, 1);
    ack(64'h0);
    tick;
    wr(25'h0001000, 16'h5A5A, 2'b11, 1'b0);
    saw_req = 0;
    saw_stall = 0;
    for (int i = 0; i < 20; i++) begin
      saw_req |= bus.sdr_req;
      saw_stall |= !bus.cpu_ready;
      tick;
    end
    check("romwr_noreq", saw_req, 0);
    check("romwr_ready", saw_stall, 0);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    rd(25'h0012342, 16'h2222);
    miss("rd2", 25'h0012340, L1);
    tick;
    rd(25'h0012344, 16'h3333);
    hit_or_miss("rd3", 25'h0012340, L1);
    tick;
    wr(25'h0012344, 16'h00AB, 2'b01, 1'b1);
    check("wr2_be", bus.sdr_be, 2'b01);
    check("wr2_a", bus.sdr_a, 25'h0012344);
    tick;
    ack(64'h0);
    tick;
    rd(25'h0012344, 16'h33AB);
    hit_or_miss("rd4", 25'h0012340, 64'h4444_33AB_2222_1111);
    tick;
    rd(25'h0040006, 16'h0000);
    check("abort_req", bus.sdr_req, 1);
    check("abort_a", bus.sdr_a, 25'h0040000);
    tick;
    reset_n = 1'b0;
    tick;
    check("abort_req_drop", bus.sdr_req, 0);
    check("abort_ready", bus.cpu_ready, 1);
    reset_n = 1'b1;
    bus.sdr_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    bus.sdr_ack = 1'b1;
    tick;
    bus.sdr_ack = 1'b0;
    tick;
    check("late_ack_req", bus.sdr_req, 0);
    check("late_ack_ready", bus.cpu_ready, 1);
    check("late_ack_din", bus.cpu_din, 0);
    rd(25'h0040006, 16'h8888);
    miss("rd5", 25'h0040000, L2);
    tick;
    bus.sdr_addr = 25'h0200020;
    bus.ram_rom_memrq = 1'b1;
    bus.writable = 1'b1;
    bus.cpu_dout = 16'h1234;
    bus.cpu_be = 2'b11;
    bus.mem_rd = 1'b1;
    bus.mem_wr = 1'b1;
    tick;
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    check("both_we", bus.sdr_we, 1);
    check("both_a", bus.sdr_a, 25'h0200020);
    check("both_data", bus.sdr_wdata, 16'h1234);
    ack(64'h0);
    repeat (5) tick;
    check("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_sdram_bridge.md
Name: cpu_sdram_bridge

Overview:
- Sits directly downstream of the CPU address decoder in the M92 main-CPU path.
- Consumes the decoder's `ram_rom_memrq`, `writable` and 25-bit `sdr_addr` for each V33 bus cycle.
- Turns each cycle into a req/ack transaction on the shared SDRAM controller's CPU port, and holds the CPU with `cpu_ready` until data or completion is available.
- Decoder outputs are combinational and stable for the whole CPU bus cycle.

Parameters:
- `LINE_WORDS`, 4: 16-bit words per SDRAM read burst (64-bit line); fixed at 4, not user-tunable.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `mem_rd` in 1: one-cycle pulse at the start of a CPU memory read.
- `mem_wr` in 1: one-cycle pulse at the start of a CPU memory write.
- `ram_rom_memrq` in 1: decoder select, cycle targets SDRAM.
- `writable` in 1: decoder flag, target is RAM.
- `sdr_addr` in 25: decoder byte address.
- `cpu_be` in 2: byte enables, [1] = high byte.
- `cpu_dout` in 16: CPU write data.
- `cpu_din` out 16: read data to CPU.
- `cpu_ready` out 1: high when no cycle is pending.
- `sdr_req` out 1: request to SDRAM controller.
- `sdr_we` out 1: write request.
- `sdr_a` out 25: request address, bit 0 forced 0; for reads bits [2:0] forced 0.
- `sdr_be` out 2: write byte enables.
- `sdr_wdata` out 16: write data.
- `sdr_rdata` in 64: read line; word n at bits [16n+15:16n].
- `sdr_ack` in 1: one-cycle completion pulse.

Behaviour:
- Reset (`reset_n`=0 at a clk edge) forces:
  - `cpu_ready`=1, `sdr_req`=0, `sdr_we`=0;
  - `sdr_a`=0, `sdr_be`=0, `sdr_wdata`=0, `cpu_din`=0;
  - FSM to IDLE; cache line invalid.
- Reset mid-transaction drops `sdr_req` the same edge. A late `sdr_ack` after reset is ignored.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE, `mem_wr` & `ram_rom_memrq` & `writable`:
  - latch address, be and data;
  - `sdr_req`=1, `sdr_we`=1, `cpu_ready`=0;
  - go to WR_WAIT.
- IDLE, `mem_wr` & `ram_rom_memrq` & !`writable` (ROM write): dropped; no SDRAM traffic; `cpu_ready` stays 1.
- IDLE, `mem_rd` & `ram_rom_memrq`, cache miss or cache disabled:
  - `sdr_req`=1, `sdr_we`=0, `sdr_a`={addr[24:3],3'b0}, `cpu_ready`=0;
  - go to RD_WAIT.
- IDLE, `mem_rd` & !`ram_rom_memrq`: ignored; another decoder target serves it.
- `mem_rd` and `mem_wr` in the same cycle: write wins; read is ignored.
- RD_WAIT on `sdr_ack`:
  - `cpu_din` = word `addr[2:1]` of `sdr_rdata`, registered;
  - `sdr_req`=0, `cpu_ready`=1 the next cycle;
  - go to IDLE.
- WR_WAIT on `sdr_ack`: `sdr_req`=0, `cpu_ready`=1 the next cycle; go to IDLE.
- Strobes arriving while not in IDLE are ignored; the CPU is stalled so they cannot legally occur.
- `sdr_req` and all request fields stay stable from assertion until the cycle after `sdr_ack`.
- Miss latency: `cpu_ready` returns 1 cycle after `sdr_ack`.
- Byte lanes: reads always return the full word (the CPU selects the byte). `sdr_be`=`cpu_be` on writes. `sdr_be`=2'b11 on reads.

Optional Feature:
- Macro: `M92_CPU_LINE_CACHE_EN`.
- When defined:
  - one 64-bit line register plus tag (addr[24:3]) and valid bit, filled on every RD_WAIT ack;
  - a read hitting a valid matching tag needs no SDRAM request: `cpu_din` is loaded next cycle and `cpu_ready` never drops;
  - a write whose addr[24:3] matches the valid tag merges the enabled bytes into the cached word at ack, so the line stays coherent.
- When undefined: no line storage; every SDRAM read goes through RD_WAIT.

Decomposition:
- Into `m92_pkg`:
  - `cpu_bridge_state_t` enum (IDLE, RD_WAIT, WR_WAIT);
  - `CPU_LINE_BITS`=64;
  - `CPU_TAG_W`=22.
- One sub-module: `cpu_line_cache` (tag/valid/line storage, hit compare, byte-merge), instantiated only under the macro.

Test Plan:
- Read 0x0012346 (ROM):
  - required: `sdr_req`=1, `sdr_a`=0x0012340, `sdr_we`=0;
  - ack with `sdr_rdata`=0x4444_3333_2222_1111 → `cpu_din`=0x4444, `cpu_ready`=1 one cycle after ack.
- Write 0xBEEF, be=2'b10, to a `writable` address → `sdr_we`=1, `sdr_be`=2'b10, `sdr_wdata`=0xBEEF held until ack; `cpu_ready` low throughout.
- ROM write (`writable`=0) → no `sdr_req` over 20 cycles; `cpu_ready` stays 1.
- Cache on: read 0x0012342 then 0x0012344 → second returns word 2 (0x3333) with zero stall and no `sdr_req`. Then write 0x00AB be=2'b01 to 0x0012344 and re-read → 0x33AB.
- Assert `reset_n`=0 during RD_WAIT → `sdr_req`=0 next edge; a late ack is ignored; the next read misses and issues a new request.
- Simultaneous `mem_rd`+`mem_wr` pulse → only the write is issued.
